// File: rtl/serial_frame_ctrl_pkg.sv
// serial_ctrl_pkg: shared types and helpers for the serial frame controller.
//   state_t    : parser states
//   BCAST_ADDR : frame address that writes every digit register
//   frame_csum : expected checksum byte for an (addr, data) pair
package serial_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } state_t;

  localparam logic [7:0] BCAST_ADDR = 8'hFF;

  function automatic logic [7:0] frame_csum(input logic [7:0] addr,
                                            input logic [7:0] data);
    return addr ^ data;
  endfunction

endpackage

// File: rtl/serial_frame_ctrl_timer.sv
// frame_timer: inter-byte gap counter for the frame parser.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   active     : parser is inside a frame (state != IDLE)
//   strobe     : a byte arrives this cycle (clears the gap)
//   expire     : combinational; the TIMEOUT_CYC-th consecutive idle cycle
//                of a frame has been reached with no byte arriving in it
// Used by serial_frame_ctrl only when FRAME_TIMEOUT_EN is defined.
module frame_timer #(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic strobe,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] gap_q;

  // A byte in the expiry cycle wins, so strobe masks expire.
  assign expire = active && !strobe && (gap_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= '0;
    end else if (strobe || !active || expire) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_q + 1'b1;
    end
  end

endmodule

// File: rtl/serial_frame_ctrl.sv
// serial_frame_ctrl: parses {SYNC, ADDR, DATA, CSUM} command frames from the
// UART receiver and writes the 7-segment digit register bank.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   rx_byte      : received byte, valid with rbyte_ready
//   rbyte_ready  : one-cycle strobe per received byte
//   digits       : NUM_DIGITS x 8-bit digit registers, digit i at [8*i+:8]
//   wr_strobe    : one-cycle pulse when digit register(s) are written
//   wr_addr      : ADDR of the last accepted write
//   frame_err    : one-cycle pulse on a rejected (or timed-out) frame
//   err_count    : saturating count of frame_err pulses
//   busy         : high while the parser is inside a frame
// Build option: define FRAME_TIMEOUT_EN to abandon a frame after
// TIMEOUT_CYC idle cycles between bytes (counted as a frame error).
//
// state | meaning
// ------+---------------------------------------------------
// IDLE  | hunting for SYNC_BYTE, other bytes dropped silently
// ADDR  | next byte is the digit address
// DATA  | next byte is the digit value
// CSUM  | next byte is the checksum; frame judged and closed
module serial_frame_ctrl
  import serial_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter logic [7:0]  DIGIT_RST   = 8'h00,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_byte,
  input  logic                    rbyte_ready,
  output logic [8*NUM_DIGITS-1:0] digits,
  output logic                    wr_strobe,
  output logic [7:0]              wr_addr,
  output logic                    frame_err,
  output logic [7:0]              err_count,
  output logic                    busy
);

  localparam logic [7:0] NUM_DIGITS_B = 8'(NUM_DIGITS);

  state_t     state_q, state_d;
  logic [7:0] addr_q, data_q;
  logic       frame_ok;
  logic       wr_en, err_en;
  logic       tmr_expire;

`ifdef FRAME_TIMEOUT_EN
  frame_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_frame_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .active(state_q != IDLE),
    .strobe(rbyte_ready),
    .expire(tmr_expire)
  );
`else
  assign tmr_expire = 1'b0;
`endif

  // Judged against the checksum byte on the bus during the CSUM strobe.
  assign frame_ok = (rx_byte == frame_csum(addr_q, data_q)) &&
                    ((addr_q < NUM_DIGITS_B) || (addr_q == BCAST_ADDR));

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    err_en  = 1'b0;
    case (state_q)
      IDLE: if (rbyte_ready && (rx_byte == SYNC_BYTE)) state_d = ADDR;
      ADDR: if (rbyte_ready) state_d = DATA;
      DATA: if (rbyte_ready) state_d = CSUM;
      CSUM: begin
        if (rbyte_ready) begin
          state_d = IDLE;
          if (frame_ok) wr_en  = 1'b1;
          else          err_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (tmr_expire) begin
      state_d = IDLE;
      err_en  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      if (rbyte_ready && (state_q == ADDR)) addr_q <= rx_byte;
      if (rbyte_ready && (state_q == DATA)) data_q <= rx_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits    <= {NUM_DIGITS{DIGIT_RST}};
      wr_strobe <= 1'b0;
      wr_addr   <= 8'h00;
      frame_err <= 1'b0;
      err_count <= 8'h00;
      busy      <= 1'b0;
    end else begin
      wr_strobe <= wr_en;
      frame_err <= err_en;
      busy      <= (state_d != IDLE);
      if (wr_en) wr_addr <= addr_q;
      if (err_en && (err_count != 8'hFF)) err_count <= err_count + 8'h01;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_en && ((addr_q == BCAST_ADDR) || (addr_q == 8'(i))))
          digits[8*i +: 8] <= data_q;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_ctrl.sv
module tb_serial_frame_ctrl;

  localparam int ND = 4;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rbyte_ready = 1'b0;
  logic [8*ND-1:0] digits;
  logic          wr_strobe;
  logic [7:0]    wr_addr;
  logic          frame_err;
  logic [7:0]    err_count;
  logic          busy;

  int tests = 0;
  int fails = 0;
  int n_wr  = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_frame_ctrl #(
    .NUM_DIGITS (ND),
    .DIGIT_RST  (8'h00),
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_byte    (rx_byte),
    .rbyte_ready(rbyte_ready),
    .digits     (digits),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .frame_err  (frame_err),
    .err_count  (err_count),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: collect bytes of a frame, judge it when four are in.
  logic [7:0] m_dig [ND];
  logic [7:0] m_buf [4];
  logic [7:0] m_wa, m_ec;
  bit         m_wr, m_err, m_busy;
  int         m_cnt, m_idle;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ND; i++) m_dig[i] = 8'h00;
      m_wa = 8'h00; m_ec = 8'h00; m_wr = 0; m_err = 0; m_busy = 0;
      m_cnt = 0; m_idle = 0;
    end else begin
      m_wr = 0;
      m_err = 0;
      if (rbyte_ready) begin
        m_idle = 0;
        if (m_cnt == 0) begin
          if (rx_byte == 8'hA5) begin m_buf[0] = rx_byte; m_cnt = 1; end
        end else begin
          m_buf[m_cnt] = rx_byte;
          m_cnt++;
          if (m_cnt == 4) begin
            int a;
            a = int'(m_buf[1]);
            if ((m_buf[3] == (m_buf[1] ^ m_buf[2])) && (a < ND || a == 255)) begin
              for (int i = 0; i < ND; i++) if (a == 255 || a == i) m_dig[i] = m_buf[2];
              m_wr = 1;
              m_wa = m_buf[1];
            end else begin
              m_err = 1;
              if (m_ec != 8'hFF) m_ec = m_ec + 8'h01;
            end
            m_cnt = 0;
          end
        end
      end else if (m_cnt != 0) begin
`ifdef FRAME_TIMEOUT_EN
        m_idle++;
        if (m_idle == TO) begin
          m_err = 1;
          if (m_ec != 8'hFF) m_ec = m_ec + 8'h01;
          m_cnt = 0;
          m_idle = 0;
        end
`endif
      end
      m_busy = (m_cnt != 0);
    end
  end

  always @(negedge clk) begin
    logic [8*ND-1:0] exp_d;
    for (int i = 0; i < ND; i++) exp_d[8*i +: 8] = m_dig[i];
    chk("model_digits", 32'(digits), 32'(exp_d));
    chk("model_wr_strobe", 32'(wr_strobe), 32'(m_wr));
    chk("model_wr_addr", 32'(wr_addr), 32'(m_wa));
    chk("model_frame_err", 32'(frame_err), 32'(m_err));
    chk("model_err_count", 32'(err_count), 32'(m_ec));
    chk("model_busy", 32'(busy), 32'(m_busy));
    if (wr_strobe === 1'b1) n_wr++;
    if (frame_err === 1'b1) n_err++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rbyte_ready = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b, input int pre);
    idle(pre);
    @(posedge clk); #1;
    rx_byte = b;
    rbyte_ready = 1'b1;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    send(8'hA5, 0); send(a, 0); send(d, 0); send(c, 0);
  endtask

  initial begin
    int wr0, err0;
    idle(3);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_err_count", 32'(err_count), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);
    rst_n = 1'b1;
    idle(2);

    frame(8'h02, 8'h3F, 8'h3D); idle(3);
    chk("f1_digits", 32'(digits), 32'h003F0000);
    chk("f1_wr_addr", 32'(wr_addr), 32'h02);
    chk("f1_err_count", 32'(err_count), 32'h0);
    chk("f1_n_wr", 32'(n_wr), 32'd1);

    frame(8'hFF, 8'h66, 8'h99); idle(3);
    chk("bcast_digits", 32'(digits), 32'h66666666);
    chk("bcast_wr_addr", 32'(wr_addr), 32'hFF);
    chk("bcast_n_wr", 32'(n_wr), 32'd2);

    frame(8'h01, 8'h10, 8'h00); frame(8'h04, 8'h10, 8'h14); idle(3);
    chk("bad_err_count", 32'(err_count), 32'd2);
    chk("bad_n_err", 32'(n_err), 32'd2);
    chk("bad_digits", 32'(digits), 32'h66666666);

    send(8'h00, 1); send(8'h13, 1); send(8'hA5, 1);
    send(8'h00, 1); send(8'h7E, 1); send(8'h7E, 1); idle(3);
    chk("junk_digits", 32'(digits), 32'h6666667E);
    chk("junk_n_err", 32'(n_err), 32'd2);
    chk("junk_n_wr", 32'(n_wr), 32'd3);

    frame(8'h03, 8'h11, 8'h12); frame(8'h00, 8'h22, 8'h22); idle(3);
    chk("b2b_digits", 32'(digits), 32'h11666622);
    chk("b2b_n_wr", 32'(n_wr), 32'd5);

    send(8'hA5, 0); send(8'h01, 0); send(8'h20, TO - 1); send(8'h21, 0); idle(3);
    chk("edge_digits", 32'(digits), 32'h11662022);
    chk("edge_n_err", 32'(n_err), 32'd2);
    chk("edge_wr_addr", 32'(wr_addr), 32'h01);

    send(8'hA5, 0); send(8'h01, 0); idle(TO + 10);
`ifdef FRAME_TIMEOUT_EN
    chk("tmo_err_count", 32'(err_count), 32'd3);
    chk("tmo_busy", 32'(busy), 32'd0);
`else
    chk("wait_err_count", 32'(err_count), 32'd2);
    chk("wait_busy", 32'(busy), 32'd1);
`endif

    rst_n = 1'b0; idle(2);
    chk("rst2_digits", 32'(digits), 32'h0);
    chk("rst2_busy", 32'(busy), 32'h0);
    rst_n = 1'b1; idle(2);

    for (int k = 0; k < 300; k++) frame(8'h01, 8'h10, 8'h00);
    idle(3);
    chk("sat_err_count", 32'(err_count), 32'hFF);

    send(8'hA5, 0); send(8'h00, 0); idle(1);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0; #1;
    chk("mid_rst_err_count", 32'(err_count), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    idle(2);
    rst_n = 1'b1; idle(2);
    wr0 = n_wr; err0 = n_err;
    frame(8'h00, 8'hAA, 8'hAA); idle(3);
    chk("post_rst_digits", 32'(digits), 32'h000000AA);
    chk("post_rst_n_err", 32'(n_err - err0), 32'd0);
    chk("post_rst_n_wr", 32'(n_wr - wr0), 32'd1);
    chk("post_rst_err_count", 32'(err_count), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
